level_shift_pipe: RTL
=====================

Name: level_shift_pipe

Overview:
- Parametrised successor to the per-row level shifter in the FDCT front end.
- Takes one row of LANES unsigned samples per beat and subtracts OFFSET.
- Converts each lane to IEEE-754 single (FDCT float path) or sign-extended 32-bit integer (fixed-point path), selected per beat.
- Native 3-stage RTL pipeline, no IP cores; valid/ready backpressure; marks the last row of each ROWS-row block for the downstream row-DCT.

Parameters:
- LANES, 8, samples per row/beat.
- IN_W, 8, input sample width; legal range 2..24, so conversion is always exact.
- OFFSET, 1<<(IN_W-1), unsigned value subtracted from every sample.
- ROWS, 8, rows per block; dout_last period.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- din  in  IN_W x LANES  unsigned samples, unpacked array [LANES-1:0].
- din_fp  in  1  per-beat mode: 1 = float output, 0 = integer output.
- din_valid  in  1  input beat valid.
- din_ready  out  1  input beat accepted when din_valid & din_ready.
- dout  out  32 x LANES  converted lanes, unpacked array [LANES-1:0].
- dout_valid  out  1  output beat valid.
- dout_ready  in  1  downstream accept.
- dout_last  out  1  high with the output beat that is row ROWS-1 of a block.

Behaviour:
- Reset: all stage valids 0, dout_valid=0, dout_last=0, dout all-zero, row counter 0. din_ready=1 in the cycle after reset deasserts.
- Pipeline:
  - S1 registers v = din - OFFSET as signed (IN_W+1) bits, plus mode.
  - S2 registers sign, |v| and leading-one position p (priority encoder).
  - S3 packs and drives the output registers.
  - Latency 3 cycles from accepted input to dout_valid when unstalled; full throughput 1 beat/cycle.
- Stall: adv = ~dout_valid | dout_ready. All stages shift only when adv=1. din_ready = adv (combinational). Stall freezes all stages including bubbles.
- Output registers hold dout/dout_last stable while dout_valid & ~dout_ready.
- Data and mode travel together; changing din_fp between beats gives a mixed stream with no flush.
- Float packing:
  - v=0 gives 0x00000000 (+0 only).
  - Otherwise sign = v<0, exponent = 127+p, mantissa = bits below the leading one, left-aligned into 23 bits, zero-filled. No rounding is needed.
- Integer packing: v sign-extended to 32 bits.
- Row counter increments on each output handshake (dout_valid & dout_ready). dout_last = (count == ROWS-1). Count wraps to 0 after ROWS-1. The counter does not advance while stalled.
- Simultaneous push and pop at full occupancy is legal and loses no data.
- rst mid-stream discards all in-flight beats and restarts the row count at 0.

Optional Feature:
- Macro LEVEL_SHIFT_PIPE_ZERO_MASK_EN.
- Defined:
  - Adds output port dout_zero (LANES bits, registered in S3 alongside dout). Bit i = 1 when lane i's shifted value v == 0.
  - Adds output zero_rows (16 bits), counting output beats where all lanes are zero. It saturates at 0xFFFF and is cleared by rst.
- Undefined: neither port exists; datapath and timing are identical.

Test Plan:
- IN_W=8, OFFSET=128, din_fp=1, all lanes = {0,255,128,129,127,1,64,200}, dout_ready=1 -> 3 cycles later dout = {0xC3000000,0x42FE0000,0x00000000,0x3F800000,0xBF800000,0xC2FE0000,0xC2800000,0x42900000}.
- Same lanes with din_fp=0 -> dout = {0xFFFFFF80,0x0000007F,0x00000000,0x00000001,0xFFFFFFFF,0xFFFFFF81,0xFFFFFFC0,0x00000048}.
- 16 back-to-back beats, dout_ready=1 -> 16 output beats on consecutive cycles; dout_last high on output beats 8 and 16 only.
- dout_ready held low 5 cycles mid-stream with din_valid=1 -> din_ready=0 once the output is valid; dout stable throughout; no beat lost or duplicated; order preserved when ready returns.
- Random din/din_fp/din_valid/dout_ready, 10k beats -> output matches the reference model bit-exactly in order; dout_last every ROWS-th handshake.
- rst pulsed 1 cycle with 3 beats in flight -> dout_valid=0 the next cycle; the next block's row 7 (8th output) asserts dout_last.

Source files
------------

// File: rtl/level_shift_pipe.sv
// ----------------------------------------------------------------------------
// level_shift_pipe
//
// Purpose:
//   Row level shifter for the FDCT front end. Each beat carries one row of
//   LANES unsigned samples. OFFSET is subtracted from every sample, and each
//   lane is then converted to one of two formats, chosen per beat by din_fp:
//     - an IEEE-754 single (float path), or
//     - a sign-extended 32-bit integer (fixed-point path).
//   The conversion is always exact because IN_W <= 24.
//   The pipeline has three registered stages with valid/ready backpressure.
//   dout_last marks the last row (row ROWS-1) of every ROWS-row block.
//
// Parameters:
//   LANES  - samples per row / beat
//   IN_W   - input sample width (2..24)
//   OFFSET - unsigned value subtracted from every sample
//   ROWS   - rows per block (period of dout_last)
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   din        in   [LANES-1:0] x IN_W unsigned samples
//   din_fp     in   1 = float output, 0 = integer output (travels with data)
//   din_valid  in   input beat valid
//   din_ready  out  input accepted when din_valid & din_ready
//   dout       out  [LANES-1:0] x 32 converted lanes
//   dout_valid out  output beat valid
//   dout_ready in   downstream accept
//   dout_last  out  high with the output beat that is row ROWS-1 of a block
//
// Optional feature (macro LEVEL_SHIFT_PIPE_ZERO_MASK_EN):
//   dout_zero  out  [LANES-1:0] per-lane flag, set when the shifted value is 0
//   zero_rows  out  16-bit saturating count of output beats with all lanes 0
// ----------------------------------------------------------------------------
module level_shift_pipe #(
    parameter int LANES  = 8,
    parameter int IN_W   = 8,
    parameter int OFFSET = 1 << (IN_W - 1),
    parameter int ROWS   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   din [LANES-1:0],
    input  logic              din_fp,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [31:0]       dout [LANES-1:0],
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last
`ifdef LEVEL_SHIFT_PIPE_ZERO_MASK_EN
    ,
    output logic [LANES-1:0]  dout_zero,
    output logic [15:0]       zero_rows
`endif
);

    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IN_W:0] OFFSET_EXT = (IN_W + 1)'(OFFSET);
    localparam logic [CW-1:0] LAST_ROW = CW'(ROWS - 1);

    // Position of the most significant set bit (0 when m is 0).
    function automatic logic [4:0] lead_one(input logic [IN_W:0] m);
        logic [4:0] pos;
        pos = 5'd0;
        for (int k = 0; k <= IN_W; k++) begin
            if (m[k]) begin
                pos = 5'(k);
            end else begin
                pos = pos;
            end
        end
        return pos;
    endfunction

    // Build the single-precision word from sign, magnitude and leading-one
    // position. The shift drops the leading one and left-aligns the bits
    // below it into the 23-bit mantissa. The magnitude never exceeds 24
    // bits, so no rounding is needed.
    function automatic logic [31:0] pack_float(input logic sgn,
                                               input logic [IN_W:0] mag,
                                               input logic [4:0] p);
        logic [47:0] t;
        logic [7:0]  e;
        t = {{(47 - IN_W){1'b0}}, mag} << (5'd23 - p);
        e = 8'd127 + {3'b000, p};
        if (mag == {(IN_W + 1){1'b0}}) begin
            return 32'h0000_0000;
        end else begin
            return {sgn, e, t[22:0]};
        end
    endfunction

    // ---------------- stage registers ----------------
    logic              adv_s;
    logic              hs_s;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_fp_q,    s1_fp_d;
    logic [IN_W:0]     s1_v_q [LANES-1:0];
    logic [IN_W:0]     s1_v_d [LANES-1:0];

    logic              s2_valid_q, s2_valid_d;
    logic              s2_fp_q,    s2_fp_d;
    logic [IN_W:0]     s2_v_q   [LANES-1:0];
    logic [IN_W:0]     s2_v_d   [LANES-1:0];
    logic [IN_W:0]     s2_mag_q [LANES-1:0];
    logic [IN_W:0]     s2_mag_d [LANES-1:0];
    logic [4:0]        s2_pos_q [LANES-1:0];
    logic [4:0]        s2_pos_d [LANES-1:0];

    logic [31:0]       dout_q [LANES-1:0];
    logic [31:0]       dout_d [LANES-1:0];
    logic              dout_valid_q, dout_valid_d;
    logic              dout_last_q,  dout_last_d;
    logic [CW-1:0]     row_cnt_q,    row_cnt_d;
    logic [LANES-1:0]  dout_zero_q,  dout_zero_d;

    // Global advance: every stage moves, bubbles included, unless the
    // output holds a beat that the downstream is refusing.
    always_comb begin
        adv_s = ~dout_valid_q | dout_ready;
        hs_s  = dout_valid_q & dout_ready;
    end

    assign din_ready = adv_s;

    // Stage 1: subtract the offset. The (IN_W+1)-bit two's-complement
    // difference is the signed shifted value.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_fp_d    = s1_fp_q;
        s1_v_d     = s1_v_q;
        if (adv_s) begin
            s1_valid_d = din_valid;
            s1_fp_d    = din_fp;
            for (int i = 0; i < LANES; i++) begin
                s1_v_d[i] = {1'b0, din[i]} - OFFSET_EXT;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2: take the magnitude and priority-encode the leading one.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_fp_d    = s2_fp_q;
        s2_v_d     = s2_v_q;
        s2_mag_d   = s2_mag_q;
        s2_pos_d   = s2_pos_q;
        if (adv_s) begin
            s2_valid_d = s1_valid_q;
            s2_fp_d    = s1_fp_q;
            for (int i = 0; i < LANES; i++) begin
                s2_v_d[i] = s1_v_q[i];
                if (s1_v_q[i][IN_W]) begin
                    s2_mag_d[i] = (~s1_v_q[i]) + {{IN_W{1'b0}}, 1'b1};
                end else begin
                    s2_mag_d[i] = s1_v_q[i];
                end
                s2_pos_d[i] = lead_one(s2_mag_d[i]);
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Stage 3: pack the lanes and compute the block-row marker. The output
    // registers hold while stalled. On a bubble the data is left unchanged.
    always_comb begin
        logic [CW-1:0] cnt_next;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        dout_d       = dout_q;
        dout_zero_d  = dout_zero_q;
        // Row counter follows output handshakes and wraps after ROWS-1.
        if (hs_s) begin
            if (row_cnt_q == LAST_ROW) begin
                cnt_next = {CW{1'b0}};
            end else begin
                cnt_next = row_cnt_q + CW'(1);
            end
        end else begin
            cnt_next = row_cnt_q;
        end
        row_cnt_d = cnt_next;
        if (adv_s) begin
            dout_valid_d = s2_valid_q;
            // A beat loaded now is the next one to hand off, so its row
            // index is the count after any handshake in this cycle.
            dout_last_d  = s2_valid_q & (cnt_next == LAST_ROW);
            if (s2_valid_q) begin
                for (int i = 0; i < LANES; i++) begin
                    dout_zero_d[i] = (s2_mag_q[i] == {(IN_W + 1){1'b0}});
                    if (s2_fp_q) begin
                        dout_d[i] = pack_float(s2_v_q[i][IN_W], s2_mag_q[i],
                                               s2_pos_q[i]);
                    end else begin
                        dout_d[i] = {{(31 - IN_W){s2_v_q[i][IN_W]}}, s2_v_q[i]};
                    end
                end
            end else begin
                dout_d = dout_q;
            end
        end else begin
            dout_valid_d = dout_valid_q;
        end
    end

    // Pipeline state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_fp_q      <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_fp_q      <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            row_cnt_q    <= {CW{1'b0}};
            dout_zero_q  <= {LANES{1'b0}};
            for (int i = 0; i < LANES; i++) begin
                s1_v_q[i]   <= {(IN_W + 1){1'b0}};
                s2_v_q[i]   <= {(IN_W + 1){1'b0}};
                s2_mag_q[i] <= {(IN_W + 1){1'b0}};
                s2_pos_q[i] <= 5'd0;
                dout_q[i]   <= 32'h0000_0000;
            end
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_fp_q      <= s1_fp_d;
            s1_v_q       <= s1_v_d;
            s2_valid_q   <= s2_valid_d;
            s2_fp_q      <= s2_fp_d;
            s2_v_q       <= s2_v_d;
            s2_mag_q     <= s2_mag_d;
            s2_pos_q     <= s2_pos_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            row_cnt_q    <= row_cnt_d;
            dout_zero_q  <= dout_zero_d;
            dout_q       <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;

`ifdef LEVEL_SHIFT_PIPE_ZERO_MASK_EN
    logic [15:0] zero_rows_q, zero_rows_d;

    // Count handed-off beats whose lanes are all zero, saturating at 0xFFFF.
    always_comb begin
        zero_rows_d = zero_rows_q;
        if (hs_s && (&dout_zero_q) && (zero_rows_q != 16'hFFFF)) begin
            zero_rows_d = zero_rows_q + 16'd1;
        end else begin
            zero_rows_d = zero_rows_q;
        end
    end

    // All-zero row counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_rows_q <= 16'd0;
        end else begin
            zero_rows_q <= zero_rows_d;
        end
    end

    assign dout_zero = dout_zero_q;
    assign zero_rows = zero_rows_q;
`endif

endmodule
